// File: rtl/mux_key_table_if.sv
// mux_key_table_if: table-update, lookup-request and response bundle.
// Ports: master drives writes, requests and rsp_ready; slave is the table.
interface mux_key_table_if #(
    parameter int NR_KEY   = 4,
    parameter int KEY_LEN  = 7,
    parameter int DATA_LEN = 32,
    parameter int IDX_W    = $clog2(NR_KEY)
);
    logic                wr_en;
    logic [IDX_W-1:0]    wr_idx;
    logic [KEY_LEN-1:0]  wr_key;
    logic [DATA_LEN-1:0] wr_data;
    logic                inv_en;
    logic                clr;

    logic                req_valid;
    logic                req_ready;
    logic [KEY_LEN-1:0]  req_key;
    logic [DATA_LEN-1:0] default_out;

    logic                rsp_valid;
    logic                rsp_ready;
    logic [DATA_LEN-1:0] rsp_data;
    logic                rsp_hit;
    logic [IDX_W-1:0]    rsp_idx;
    logic                rsp_multi;

    modport master (
        output wr_en, wr_idx, wr_key, wr_data, inv_en, clr,
        output req_valid, req_key, default_out, rsp_ready,
        input  req_ready, rsp_valid, rsp_data, rsp_hit, rsp_idx, rsp_multi
    );

    modport slave (
        input  wr_en, wr_idx, wr_key, wr_data, inv_en, clr,
        input  req_valid, req_key, default_out, rsp_ready,
        output req_ready, rsp_valid, rsp_data, rsp_hit, rsp_idx, rsp_multi
    );
endinterface

// File: rtl/mux_key_table.sv
// mux_key_table: programmable {key,data} table with registered lookup.
// Ports: clk, rst (sync, active high), bus (slave: writes, req, rsp).
module mux_key_table #(
    parameter int NR_KEY      = 4,
    parameter int KEY_LEN     = 7,
    parameter int DATA_LEN    = 32,
    parameter bit HAS_DEFAULT = 1'b1,
    parameter bit MERGE_MODE  = 1'b0
) (
    input logic             clk,
    input logic             rst,
    mux_key_table_if.slave  bus
);
    localparam int IDX_W = $clog2(NR_KEY);
    localparam logic [IDX_W:0] KEY_CNT = (IDX_W+1)'(NR_KEY);

    logic [NR_KEY-1:0]   vld_q;
    logic [KEY_LEN-1:0]  key_q  [NR_KEY];
    logic [DATA_LEN-1:0] data_q [NR_KEY];

    logic                rsp_valid_q;
    logic [DATA_LEN-1:0] rsp_data_q, rsp_data_d;
    logic                rsp_hit_q, rsp_hit_d;
    logic [IDX_W-1:0]    rsp_idx_q, rsp_idx_d;
    logic                rsp_multi_q, rsp_multi_d;

    logic                accept;
    logic                wr_ok;
    logic [DATA_LEN-1:0] first_data;
    logic [DATA_LEN-1:0] or_data;

    assign bus.req_ready = !rsp_valid_q || bus.rsp_ready;
    assign accept        = bus.req_valid && bus.req_ready;
    // Out-of-range indices only exist when NR_KEY is not a power of two.
    assign wr_ok         = {1'b0, bus.wr_idx} < KEY_CNT;

    // Match against pre-edge table contents (read-before-write).
    always_comb begin
        rsp_hit_d   = 1'b0;
        rsp_idx_d   = '0;
        rsp_multi_d = 1'b0;
        first_data  = '0;
        or_data     = '0;
        for (int i = 0; i < NR_KEY; i++) begin
            if (vld_q[i] && key_q[i] == bus.req_key) begin
                if (rsp_hit_d) begin
                    rsp_multi_d = 1'b1;
                end else begin
                    rsp_hit_d  = 1'b1;
                    rsp_idx_d  = IDX_W'(i);
                    first_data = data_q[i];
                end
                or_data = or_data | data_q[i];
            end
        end
        if (rsp_hit_d)
            rsp_data_d = MERGE_MODE ? or_data : first_data;
        else
            rsp_data_d = HAS_DEFAULT ? bus.default_out : '0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            vld_q <= '0;
            for (int i = 0; i < NR_KEY; i++) begin
                key_q[i]  <= '0;
                data_q[i] <= '0;
            end
        end else if (bus.clr) begin
            vld_q <= '0;
        end else if (wr_ok) begin
            if (bus.inv_en) begin
                vld_q[bus.wr_idx] <= 1'b0;
            end else if (bus.wr_en) begin
                vld_q[bus.wr_idx]  <= 1'b1;
                key_q[bus.wr_idx]  <= bus.wr_key;
                data_q[bus.wr_idx] <= bus.wr_data;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
            rsp_hit_q   <= 1'b0;
            rsp_idx_q   <= '0;
            rsp_multi_q <= 1'b0;
        end else if (accept) begin
            rsp_valid_q <= 1'b1;
            rsp_data_q  <= rsp_data_d;
            rsp_hit_q   <= rsp_hit_d;
            rsp_idx_q   <= rsp_idx_d;
            rsp_multi_q <= rsp_multi_d;
        end else if (bus.rsp_ready) begin
            rsp_valid_q <= 1'b0;
        end
    end

    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_data  = rsp_data_q;
    assign bus.rsp_hit   = rsp_hit_q;
    assign bus.rsp_idx   = rsp_idx_q;
    assign bus.rsp_multi = rsp_multi_q;
endmodule

// File: tb/tb_mux_key_table.sv
// tb_mux_key_table: scoreboard bench with a behavioural table model.
// Ports: none; drives mux_key_table through mux_key_table_if.
module tb_mux_key_table;
    localparam int NR_KEY   = 4;
    localparam int KEY_LEN  = 7;
    localparam int DATA_LEN = 32;
    localparam int IDX_W    = $clog2(NR_KEY);
    localparam bit HAS_DEF  = 1'b1;
    localparam bit MERGE    = 1'b0;

    typedef struct {
        logic [DATA_LEN-1:0] data;
        logic                hit;
        logic [IDX_W-1:0]    idx;
        logic                multi;
    } rsp_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    mux_key_table_if #(.NR_KEY(NR_KEY), .KEY_LEN(KEY_LEN),
                       .DATA_LEN(DATA_LEN)) bus ();

    mux_key_table #(
        .NR_KEY(NR_KEY), .KEY_LEN(KEY_LEN), .DATA_LEN(DATA_LEN),
        .HAS_DEFAULT(HAS_DEF), .MERGE_MODE(MERGE)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    int n_vec = 0;
    int n_mis = 0;

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_mis++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Reference model: table contents and one-deep response occupancy.
    bit                  m_vld  [NR_KEY];
    bit [KEY_LEN-1:0]    m_key  [NR_KEY];
    bit [DATA_LEN-1:0]   m_data [NR_KEY];
    bit                  m_valid = 1'b0;
    rsp_t                q[$];

    function automatic rsp_t lookup(input logic [KEY_LEN-1:0] k,
                                    input logic [DATA_LEN-1:0] dflt);
        rsp_t r;
        int   hits[$];
        for (int i = 0; i < NR_KEY; i++)
            if (m_vld[i] && m_key[i] == k) hits.push_back(i);
        r.hit   = hits.size() > 0;
        r.multi = hits.size() > 1;
        r.idx   = r.hit ? IDX_W'(hits[0]) : '0;
        r.data  = HAS_DEF ? dflt : '0;
        if (r.hit) begin
            r.data = MERGE ? '0 : m_data[hits[0]];
            if (MERGE)
                foreach (hits[j]) r.data = r.data | m_data[hits[j]];
        end
        return r;
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NR_KEY; i++) begin
                m_vld[i] = 0; m_key[i] = 0; m_data[i] = 0;
            end
            m_valid = 1'b0;
            q.delete();
        end else begin
            if (bus.req_valid && (!m_valid || bus.rsp_ready)) begin
                q.push_back(lookup(bus.req_key, bus.default_out));
                m_valid = 1'b1;
            end else if (bus.rsp_ready) begin
                m_valid = 1'b0;
            end
            if (bus.clr) begin
                for (int i = 0; i < NR_KEY; i++) m_vld[i] = 0;
            end else if (int'(bus.wr_idx) < NR_KEY) begin
                if (bus.inv_en) begin
                    m_vld[bus.wr_idx] = 0;
                end else if (bus.wr_en) begin
                    m_vld[bus.wr_idx]  = 1;
                    m_key[bus.wr_idx]  = bus.wr_key;
                    m_data[bus.wr_idx] = bus.wr_data;
                end
            end
        end
    end

    // Monitor: compare whatever the DUT presents against the queue front.
    always @(negedge clk) begin
        chk("rsp_valid", 64'(bus.rsp_valid), 64'(m_valid));
        chk("req_ready", 64'(bus.req_ready), 64'(!m_valid || bus.rsp_ready));
        if (bus.rsp_valid) begin
            if (q.size() == 0) begin
                chk("rsp_unexpected", 64'(1), 64'(0));
            end else begin
                chk("rsp_data",  64'(bus.rsp_data),  64'(q[0].data));
                chk("rsp_hit",   64'(bus.rsp_hit),   64'(q[0].hit));
                chk("rsp_idx",   64'(bus.rsp_idx),   64'(q[0].idx));
                chk("rsp_multi", 64'(bus.rsp_multi), 64'(q[0].multi));
                if (bus.rsp_ready) void'(q.pop_front());
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.wr_en = 0; bus.inv_en = 0; bus.clr = 0;
        bus.wr_idx = '0; bus.wr_key = '0; bus.wr_data = '0;
        bus.req_valid = 0; bus.req_key = '0; bus.default_out = '0;
        bus.rsp_ready = 1;
    endtask

    task automatic wr(input int idx, input logic [KEY_LEN-1:0] k,
                      input logic [DATA_LEN-1:0] d);
        bus.wr_en = 1; bus.wr_idx = IDX_W'(idx);
        bus.wr_key = k; bus.wr_data = d;
        step();
        bus.wr_en = 0;
    endtask

    task automatic req(input logic [KEY_LEN-1:0] k);
        bus.req_valid = 1; bus.req_key = k;
        step();
        bus.req_valid = 0;
    endtask

    task automatic chk_zero(input string name);
        chk({name, "_valid"}, 64'(bus.rsp_valid), 64'(0));
        chk({name, "_data"},  64'(bus.rsp_data),  64'(0));
        chk({name, "_hit"},   64'(bus.rsp_hit),   64'(0));
        chk({name, "_idx"},   64'(bus.rsp_idx),   64'(0));
        chk({name, "_multi"}, 64'(bus.rsp_multi), 64'(0));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [KEY_LEN-1:0] keys [4];
        keys[0] = 7'h33; keys[1] = 7'h6F; keys[2] = 7'h13; keys[3] = 7'h33;
        idle();
        rst = 1;
        step(); step();
        rst = 0;
        chk_zero("reset");

        bus.default_out = 32'hDEAD_BEEF;
        req(7'h13);
        chk("miss_data", 64'(bus.rsp_data), 64'(32'hDEAD_BEEF));
        chk("miss_hit",  64'(bus.rsp_hit),  64'(0));
        chk("miss_idx",  64'(bus.rsp_idx),  64'(0));
        step();

        wr(2, 7'h33, 32'h0000_00A5);
        req(7'h33);
        chk("e2_hit",   64'(bus.rsp_hit),   64'(1));
        chk("e2_idx",   64'(bus.rsp_idx),   64'(2));
        chk("e2_data",  64'(bus.rsp_data),  64'(32'hA5));
        chk("e2_multi", 64'(bus.rsp_multi), 64'(0));

        wr(1, 7'h6F, 32'h0F0);
        wr(3, 7'h6F, 32'h00F);
        req(7'h6F);
        chk("dup_data",  64'(bus.rsp_data),
            64'(MERGE ? 32'h0FF : 32'h0F0));
        chk("dup_idx",   64'(bus.rsp_idx),   64'(1));
        chk("dup_multi", 64'(bus.rsp_multi), 64'(1));

        bus.req_valid = 1; bus.req_key = 7'h33;
        step();
        bus.rsp_ready = 0; bus.req_key = 7'h6F;
        repeat (3) begin
            step();
            chk("stall_ready", 64'(bus.req_ready), 64'(0));
            chk("stall_data",  64'(bus.rsp_data),  64'(32'hA5));
        end
        bus.rsp_ready = 1;
        for (int k = 0; k < 4; k++) begin
            step();
            chk("b2b_valid", 64'(bus.rsp_valid), 64'(1));
            bus.req_key = keys[k];
        end
        bus.req_valid = 0;
        step(); step();

        bus.default_out = 32'h1234;
        bus.wr_en = 1; bus.wr_idx = '0;
        bus.wr_key = 7'h05; bus.wr_data = 32'h1;
        bus.req_valid = 1; bus.req_key = 7'h05;
        step();
        bus.wr_en = 0;
        chk("rbw_hit",  64'(bus.rsp_hit),  64'(0));
        chk("rbw_data", 64'(bus.rsp_data), 64'(32'h1234));
        step();
        chk("after_hit",  64'(bus.rsp_hit),  64'(1));
        chk("after_data", 64'(bus.rsp_data), 64'(1));
        bus.req_valid = 0;
        bus.inv_en = 1; bus.wr_idx = '0;
        step();
        bus.inv_en = 0;
        req(7'h05);
        chk("inv_hit", 64'(bus.rsp_hit), 64'(0));

        bus.inv_en = 1; bus.wr_en = 1; bus.wr_idx = IDX_W'(2);
        bus.wr_key = 7'h44; bus.wr_data = 32'h99;
        step();
        bus.inv_en = 0; bus.wr_en = 0;
        req(7'h33);
        chk("invwr_hit", 64'(bus.rsp_hit), 64'(0));
        req(7'h44);
        chk("invwr_hit2", 64'(bus.rsp_hit), 64'(0));

        bus.clr = 1; bus.wr_en = 1; bus.wr_idx = IDX_W'(1);
        bus.wr_key = 7'h6F; bus.wr_data = 32'h55;
        step();
        bus.clr = 0; bus.wr_en = 0;
        req(7'h6F);
        chk("clr_hit", 64'(bus.rsp_hit), 64'(0));

        wr(0, 7'h33, 32'hCAFE);
        bus.rsp_ready = 0;
        req(7'h33);
        step();
        chk("pre_rst_valid", 64'(bus.rsp_valid), 64'(1));
        rst = 1;
        step();
        rst = 0;
        chk_zero("rst_drop");
        bus.rsp_ready = 1;
        step();

        for (int c = 0; c < 2000; c++) begin
            rst          = ($urandom_range(0, 299) == 0);
            bus.clr      = ($urandom_range(0, 99) == 0);
            bus.inv_en   = ($urandom_range(0, 9) == 0);
            bus.wr_en    = ($urandom_range(0, 3) == 0);
            bus.wr_idx   = IDX_W'($urandom_range(0, NR_KEY - 1));
            bus.wr_key   = KEY_LEN'($urandom_range(0, 5));
            bus.wr_data  = DATA_LEN'($urandom);
            bus.req_valid = ($urandom_range(0, 2) != 0);
            bus.req_key  = KEY_LEN'($urandom_range(0, 6));
            bus.default_out = DATA_LEN'($urandom);
            bus.rsp_ready = ($urandom_range(0, 3) != 0);
            step();
        end
        rst = 0;
        idle();
        repeat (4) step();
        chk("drain_empty", 64'(q.size()), 64'(0));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
        $finish;
    end
endmodule

// File: doc/mux_key_table.md
Name: mux_key_table

Overview:
- Programmable, registered successor to the combinational key/data mux used in the decode path.
- Holds NR_KEY runtime-writable {key, data} entries, each with its own valid bit.
- Accepts lookup requests through a valid/ready handshake and returns a registered result: data, hit flag, hit index and multi-hit flag.
- Used for CSR/opcode decode tables and small translation lookups that firmware or the pipeline must reprogram.

Parameters:
- NR_KEY, 4, number of table entries (>= 2); localparam IDX_W = $clog2(NR_KEY).
- KEY_LEN, 7, key width in bits.
- DATA_LEN, 32, data width in bits.
- HAS_DEFAULT, 1, 1: a miss returns default_out; 0: a miss returns all-zero data.
- MERGE_MODE, 0, 0: lowest-index hit wins; 1: data of all hitting entries is bitwise ORed.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- wr_en  in  1  write entry wr_idx with {wr_key, wr_data} and set its valid bit.
- wr_idx  in  IDX_W  entry index for write or invalidate.
- wr_key  in  KEY_LEN  key to store.
- wr_data  in  DATA_LEN  data to store.
- inv_en  in  1  clear the valid bit of entry wr_idx.
- clr  in  1  clear the valid bits of all entries.
- req_valid  in  1  lookup request present.
- req_ready  out  1  block can accept a request this cycle.
- req_key  in  KEY_LEN  key to look up.
- default_out  in  DATA_LEN  miss value, sampled with the request.
- rsp_valid  out  1  response register holds a result.
- rsp_ready  in  1  consumer accepts the response.
- rsp_data  out  DATA_LEN  looked-up data.
- rsp_hit  out  1  at least one valid entry matched.
- rsp_idx  out  IDX_W  lowest matching index; 0 on a miss.
- rsp_multi  out  1  more than one valid entry matched.

Behaviour:

Reset:
- rst high at a clock edge: all valid bits cleared and all entry keys and data zeroed.
- rsp_valid=0, rsp_data=0, rsp_hit=0, rsp_idx=0, rsp_multi=0.
- rst dominates every other input in the same cycle.
- Reset during an outstanding response drops that response; no rsp_valid follows.

Table update (priority clr > inv_en > wr_en):
- clr=1: every valid bit is 0 after the edge.
- inv_en=1 and wr_en=1 in the same cycle: entry wr_idx ends invalid, and its key/data are not written.
- wr_idx >= NR_KEY (NR_KEY not a power of two): write and invalidate are ignored.
- Updates take effect at the edge. A lookup accepted in the same cycle compares against pre-edge contents (read-before-write).

Lookup:
- req_ready = !rsp_valid || rsp_ready (single-entry output register, full throughput).
- A request is accepted when req_valid && req_ready.
- On acceptance, matches are evaluated combinationally against valid entries only. Result is registered, so latency is exactly 1 cycle: rsp_valid=1 on the next cycle.
- MERGE_MODE=0: rsp_data is the data of the lowest-index matching entry.
- MERGE_MODE=1: rsp_data is the OR of the data of all matching entries.
- Miss: rsp_data = default_out sampled at acceptance if HAS_DEFAULT=1, else 0. rsp_hit=0, rsp_idx=0, rsp_multi=0.
- Response is held stable while rsp_valid && !rsp_ready.
- rsp_valid falls after rsp_valid && rsp_ready with no new acceptance.
- Back-to-back: accept and retire in the same cycle gives continuous rsp_valid.
- Invalid entries never match, even if their stored key equals req_key.

Test Plan:
- Reset, then req_key=7'h13 with default_out=32'hDEAD_BEEF, HAS_DEFAULT=1 -> next cycle rsp_valid=1, rsp_hit=0, rsp_data=32'hDEAD_BEEF, rsp_idx=0.
- Write entry 2 = {7'h33, 32'h0000_00A5}, then look up 7'h33 -> rsp_hit=1, rsp_idx=2, rsp_data=32'hA5, rsp_multi=0, exactly 1 cycle after acceptance.
- Entries 1 and 3 both key 7'h6F, data 32'h0F0 and 32'h00F -> MERGE_MODE=0: rsp_data=32'h0F0, rsp_idx=1, rsp_multi=1; MERGE_MODE=1: rsp_data=32'h0FF.
- Hold rsp_ready=0 for 3 cycles with req_valid=1 -> req_ready=0 and rsp fields stable. Raise rsp_ready: four back-to-back requests produce four consecutive rsp_valid cycles.
- Write entry 0 = {7'h05, 32'h1} in the same cycle a lookup of 7'h05 is accepted -> miss. A lookup one cycle later -> hit, rsp_data=1. Then inv_en on idx 0 -> lookup misses.
- clr together with wr_en to entry 1 -> all entries invalid. Also assert rst while rsp_valid=1 with rsp_ready=0 -> rsp_valid=0 next cycle and all outputs zero.
